cpu_lsu: RTL and testbench
==========================

// Module: cpu_lsu
// PURPOSE
//   Memory-stage load/store unit. Drives a valid/ready data-memory bus for loads/stores in M.
//   Holds the pipeline by raising stall_m until each access completes; stall_m feeds the hazard unit,
//   which stalls F/D/E and freezes M. Provides lane-select and sign/zero extension of load data.
//   Flags misaligned accesses and bus timeouts.
// PARAMETERS
//   ADDR_WIDTH      32   byte-address width on bus and input
//   TIMEOUT_CYCLES  64   max cycles in REQ+WAIT_RESP before abort; 0 disables timeout
// PORTS
//   clk            in   1   clock, all state on rising edge
//   rst            in   1   synchronous reset, active-high
//   mem_read_m     in   1   M-stage instruction is a load
//   mem_write_m    in   1   M-stage instruction is a store
//   funct3_m       in   3   access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr_m         in   AW  byte address (ALU result)
//   wdata_m        in   32  store data (rs2), low bits used
//   read_data_m    out  32  extended load data, valid when done_m
//   done_m         out  1   access complete this cycle
//   stall_m        out  1   stall request to hazard unit
//   misaligned_m   out  1   one-cycle pulse, access suppressed
//   bus_error_m    out  1   one-cycle pulse on timeout
//   req_valid      out  1   bus request valid
//   req_ready      in   1   bus accepts request when valid&&ready
//   req_we         out  1   1 = write
//   req_addr       out  AW  word-aligned address, [1:0]=0
//   req_wdata      out  32  lane-replicated store data
//   req_wstrb      out  4   byte enables (0 on reads)
//   resp_valid     in   1   read data valid, >=1 cycle after read acceptance
//   resp_rdata     in   32  read word
// BEHAVIOUR
//   - Reset: state IDLE, timeout counter 0, all outputs 0. Reset aborts in-flight access; later resp_valid ignored.
//   - op = mem_read_m|mem_write_m; both high is treated as a load.
//   - Misaligned: H with addr[0]=1, or W with addr[1:0]!=0. In IDLE: misaligned_m=1 and done_m=1 combinationally,
//     stall_m=0, read_data_m=0, no bus request; state stays IDLE.
//   - stall_m = op && !misaligned && state!=DONE (combinational).
//   - States:
//     IDLE: aligned op -> REQ, latching we/addr/wdata/wstrb/funct3/addr[1:0].
//     REQ: req_valid=1, bus fields held stable until accepted.
//       accepted store -> DONE; accepted load -> WAIT_RESP.
//     WAIT_RESP: resp_valid -> DONE, latch extended rdata.
//     DONE: done_m=1, stall_m=0, read_data_m valid; unconditionally -> IDLE next cycle (pipeline advances).
//   - Minimum stall: load 3 cycles (IDLE, REQ, WAIT_RESP); store 2 cycles (IDLE, REQ). Stores are posted.
//   - Store lanes:
//     SB: wdata[7:0] in all 4 lanes, wstrb = 1<<addr[1:0].
//     SH: {2{wdata[15:0]}}, wstrb = addr[1] ? 1100 : 0011.
//     SW: wdata, wstrb = 1111.
//   - Load extend: select byte/half from addr[1:0]. B/H sign-extend, BU/HU zero-extend, W passthrough.
//     Other funct3 values are treated as W.
//   - Timeout: counter clears on IDLE->REQ and increments each cycle in REQ/WAIT_RESP.
//     At TIMEOUT_CYCLES-1 with no completion this cycle: -> DONE, bus_error_m=1 in DONE, read_data_m=0.
//     req_valid drops on abort.
//   - Completion wins over timeout in the same cycle. Counter saturates; no wrap.
//   - read_data_m and done_m are registered in DONE (except the misaligned path). read_data_m holds its value
//     until the next DONE; it clears to 0 on reset.
// STRUCTURE
//   - cpu_lsu.vh:
//     LSU_IDLE/REQ/WAIT_RESP/DONE 2-bit encodings.
//     FUNCT3_B/H/W/BU/HU constants, shared with the decoder.
//   - Sub-module cpu_load_extend: combinational (rdata, byte_off, funct3) -> 32-bit extended result.
//     Reused by the bench model.
// TESTING
//   1. LW addr=0x100, req_ready=1, resp 1 cycle later with 0xDEADBEEF -> req_addr=0x100, stall_m 3 cycles,
//      done_m with 0xDEADBEEF.
//   2. LB addr=0x103, rdata=0x80FF_0000 -> 0xFFFFFF80. LBU -> 0x00000080. LHU addr=0x102 -> 0x000080FF.
//   3. SB addr=0x201, wdata=0xAB, req_ready low 2 cycles -> req fields stable, wstrb=0010, wdata=0xABABABAB,
//      stall_m 4 cycles.
//   4. SH addr=0x301 -> misaligned_m=1, no req_valid, stall_m=0. LW addr=0x302 -> same.
//   5. TIMEOUT_CYCLES=8, load with req_ready=0 forever -> bus_error_m after 8 cycles in REQ, req_valid drops,
//      back to IDLE.
//   6. rst asserted in WAIT_RESP, late resp_valid -> ignored. All outputs 0; next LW completes normally.

Source files
------------

// File: rtl/cpu_lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
package cpu_lsu_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE      = 2'd0,
        LSU_REQ       = 2'd1,
        LSU_WAIT_RESP = 2'd2,
        LSU_DONE      = 2'd3
    } lsu_state_e;

    // Access size/sign encodings, shared with the decoder.
    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

    // Size is funct3[1:0]: 00 byte, 01 half, anything else is treated as a word.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/cpu_lsu_if.sv
// Valid/ready data-memory bus between the LSU (master) and memory (slave).
interface cpu_lsu_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic [3:0]            req_wstrb;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/cpu_load_extend.sv
// Load lane select plus sign/zero extension of a 32-bit memory word.
module cpu_load_extend
    import cpu_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Pick the addressed byte/half, then extend according to funct3.
    always_comb begin
        byte_v = rdata[{byte_off, 3'b000} +: 8];
        half_v = byte_off[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            FUNCT3_B:  result = {{24{byte_v[7]}}, byte_v};
            FUNCT3_BU: result = {24'd0, byte_v};
            FUNCT3_H:  result = {{16{half_v[15]}}, half_v};
            FUNCT3_HU: result = {16'd0, half_v};
            default:   result = rdata;
        endcase
    end
endmodule

// File: rtl/cpu_lsu.sv
// Memory-stage load/store unit: drives the data bus, stalls M until the access
// completes, flags misaligned accesses and aborts accesses that exceed the timeout.
module cpu_lsu
    import cpu_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read_m,
    input  logic                  mem_write_m,
    input  logic [2:0]            funct3_m,
    input  logic [ADDR_WIDTH-1:0] addr_m,
    input  logic [31:0]           wdata_m,
    output logic [31:0]           read_data_m,
    output logic                  done_m,
    output logic                  stall_m,
    output logic                  misaligned_m,
    output logic                  bus_error_m,
    cpu_lsu_if.master             bus
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    lsu_state_e            state;
    logic [CNT_W-1:0]      cnt;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic [2:0]            f3_q;
    logic [1:0]            off_q;
    logic [31:0]           rdata_q;
    logic                  err_q;

    logic        op, mis, idle_mis, timeout_hit;
    logic [31:0] st_wdata, ext_data;
    logic [3:0]  st_wstrb;

    cpu_load_extend u_ext (
        .rdata    (bus.resp_rdata),
        .byte_off (off_q),
        .funct3   (f3_q),
        .result   (ext_data)
    );

    // Misalignment, stall and done decode; misaligned accesses never leave IDLE.
    always_comb begin
        op           = mem_read_m | mem_write_m;
        mis          = is_misaligned(funct3_m, addr_m[1:0]);
        idle_mis     = (state == LSU_IDLE) && op && mis;
        misaligned_m = idle_mis;
        done_m       = (state == LSU_DONE) || idle_mis;
        stall_m      = op && !mis && (state != LSU_DONE);
        read_data_m  = idle_mis ? 32'd0 : rdata_q;
        bus_error_m  = err_q;
        timeout_hit  = TIMEOUT_EN && (cnt == CNT_LAST);
    end

    // Store lane replication and byte enables; loads carry no strobes.
    always_comb begin
        case (funct3_m[1:0])
            2'b00: begin
                st_wdata = {4{wdata_m[7:0]}};
                st_wstrb = 4'b0001 << addr_m[1:0];
            end
            2'b01: begin
                st_wdata = {2{wdata_m[15:0]}};
                st_wstrb = addr_m[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = wdata_m;
                st_wstrb = 4'b1111;
            end
        endcase
        if (mem_read_m) st_wstrb = 4'b0000;
    end

    assign bus.req_valid = (state == LSU_REQ);
    assign bus.req_we    = we_q;
    assign bus.req_addr  = addr_q;
    assign bus.req_wdata = wdata_q;
    assign bus.req_wstrb = wstrb_q;

    // Access FSM: latch request in IDLE, hold until accepted, wait for read data,
    // then one DONE cycle; completion takes priority over the timeout abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= LSU_IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    err_q <= 1'b0;
                    if (op && !mis) begin
                        state   <= LSU_REQ;
                        cnt     <= '0;
                        we_q    <= !mem_read_m;
                        addr_q  <= {addr_m[ADDR_WIDTH-1:2], 2'b00};
                        wdata_q <= st_wdata;
                        wstrb_q <= st_wstrb;
                        f3_q    <= funct3_m;
                        off_q   <= addr_m[1:0];
                    end
                end
                LSU_REQ: begin
                    if (cnt != '1) cnt <= cnt + 1'b1;
                    if (bus.req_ready) begin
                        state <= we_q ? LSU_DONE : LSU_WAIT_RESP;
                    end else if (timeout_hit) begin
                        state   <= LSU_DONE;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                LSU_WAIT_RESP: begin
                    if (cnt != '1) cnt <= cnt + 1'b1;
                    if (bus.resp_valid) begin
                        state   <= LSU_DONE;
                        rdata_q <= ext_data;
                    end else if (timeout_hit) begin
                        state   <= LSU_DONE;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                default: begin
                    state <= LSU_IDLE;
                    err_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_lsu.sv
// Self-checking bench for cpu_lsu: directed cases plus randomized loads/stores
// checked against a behavioural byte-lane model.
module tb_cpu_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_m, mem_write_m;
    logic [2:0]  funct3_m;
    logic [31:0] addr_m, wdata_m;
    logic [31:0] read_data_m;
    logic        done_m, stall_m, misaligned_m, bus_error_m;

    int errors = 0;
    int checks = 0;

    cpu_lsu_if #(.ADDR_WIDTH(32)) bus ();

    cpu_lsu #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read_m   (mem_read_m),
        .mem_write_m  (mem_write_m),
        .funct3_m     (funct3_m),
        .addr_m       (addr_m),
        .wdata_m      (wdata_m),
        .read_data_m  (read_data_m),
        .done_m       (done_m),
        .stall_m      (stall_m),
        .misaligned_m (misaligned_m),
        .bus_error_m  (bus_error_m),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    // Reference load result: shift the addressed lane down, then extend.
    function automatic logic [31:0] m_load(input logic [31:0] w, input int off, input logic [2:0] f3);
        logic [31:0] s;
        s = w >> (8 * off);
        case (f3)
            3'b000:  return 32'($signed(s[7:0]));
            3'b100:  return {24'd0, s[7:0]};
            3'b001:  return 32'($signed(s[15:0]));
            3'b101:  return {16'd0, s[15:0]};
            default: return w;
        endcase
    endfunction

    // One complete access: rw cycles of req_ready low, pw extra cycles before resp_valid.
    task automatic access(input bit ld, input bit both, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int rw, input int pw, input logic [31:0] rdata);
        int n, off, stalls, exp_stalls;
        bit mis;
        logic [3:0]  strb;
        logic [31:0] rep, exp_rd;
        n   = size_of(f3);
        off = int'(addr[1:0]);
        mis = (off % n) != 0;
        strb = ld ? 4'b0000 : 4'(((1 << n) - 1) << off);
        for (int i = 0; i < 4; i++) rep[8*i +: 8] = wdata[8*(i % n) +: 8];
        exp_rd = m_load(rdata, off, f3);
        exp_stalls = 2 + rw + (ld ? pw + 1 : 0);

        @(negedge clk);
        mem_read_m  = ld;
        mem_write_m = !ld || both;
        funct3_m    = f3;
        addr_m      = addr;
        wdata_m     = wdata;
        #1;
        if (mis) begin
            chk("mis_flag", 32'(misaligned_m), 1);
            chk("mis_done", 32'(done_m), 1);
            chk("mis_stall", 32'(stall_m), 0);
            chk("mis_req_valid", 32'(bus.req_valid), 0);
            chk("mis_rdata", read_data_m, 0);
            @(negedge clk);
            mem_read_m = 0; mem_write_m = 0;
            #1;
            chk("mis_after_req_valid", 32'(bus.req_valid), 0);
            chk("mis_after_flag", 32'(misaligned_m), 0);
            return;
        end
        chk("idle_misaligned", 32'(misaligned_m), 0);
        chk("idle_done", 32'(done_m), 0);
        chk("idle_req_valid", 32'(bus.req_valid), 0);
        stalls = int'(stall_m);
        @(negedge clk);
        for (int i = 0; i <= rw; i++) begin
            bus.req_ready = (i == rw);
            #1;
            chk("req_valid", 32'(bus.req_valid), 1);
            chk("req_we", 32'(bus.req_we), 32'(!ld));
            chk("req_addr", bus.req_addr, addr & 32'hFFFF_FFFC);
            chk("req_wstrb", 32'(bus.req_wstrb), 32'(strb));
            if (!ld) chk("req_wdata", bus.req_wdata, rep);
            chk("req_done", 32'(done_m), 0);
            stalls += int'(stall_m);
            @(negedge clk);
        end
        bus.req_ready = 0;
        if (ld) begin
            for (int j = 0; j <= pw; j++) begin
                bus.resp_valid = (j == pw);
                bus.resp_rdata = (j == pw) ? rdata : $urandom;
                #1;
                chk("wait_req_valid", 32'(bus.req_valid), 0);
                chk("wait_done", 32'(done_m), 0);
                stalls += int'(stall_m);
                @(negedge clk);
            end
            bus.resp_valid = 0;
        end
        #1;
        chk("done_flag", 32'(done_m), 1);
        chk("done_stall", 32'(stall_m), 0);
        chk("done_bus_error", 32'(bus_error_m), 0);
        chk("done_req_valid", 32'(bus.req_valid), 0);
        if (ld) chk("load_data", read_data_m, exp_rd);
        chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
        mem_read_m = 0; mem_write_m = 0;
        @(negedge clk);
        #1;
        chk("back_idle_done", 32'(done_m), 0);
    endtask

    initial begin
        logic [2:0] ld_f3 [7];
        logic [2:0] st_f3 [3];
        ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b011};
        st_f3 = '{3'b000, 3'b001, 3'b010};

        rst = 1; mem_read_m = 0; mem_write_m = 0; funct3_m = 0; addr_m = 0; wdata_m = 0;
        bus.req_ready = 0; bus.resp_valid = 0; bus.resp_rdata = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_read_data", read_data_m, 0);
        chk("rst_done", 32'(done_m), 0);
        chk("rst_stall", 32'(stall_m), 0);
        chk("rst_req_valid", 32'(bus.req_valid), 0);
        chk("rst_bus_error", 32'(bus_error_m), 0);
        rst = 0;

        // Directed: word load, sub-word loads, stalled byte store, misaligned cases.
        access(1, 0, 3'b010, 32'h100, 0, 0, 0, 32'hDEADBEEF);
        access(1, 0, 3'b000, 32'h103, 0, 0, 0, 32'h80FF_0000);
        access(1, 0, 3'b100, 32'h103, 0, 0, 0, 32'h80FF_0000);
        access(1, 0, 3'b101, 32'h102, 0, 1, 2, 32'h80FF_0000);
        access(0, 0, 3'b000, 32'h201, 32'h0000_00AB, 2, 0, 0);
        access(0, 0, 3'b001, 32'h302, 32'h1234_5678, 0, 0, 0);
        access(0, 0, 3'b001, 32'h301, 32'h1234_5678, 0, 0, 0);
        access(1, 0, 3'b010, 32'h302, 0, 0, 0, 0);
        access(1, 1, 3'b001, 32'h10E, 32'hFFFF_FFFF, 1, 0, 32'h8001_7FFE);
        // Completion on the last allowed cycle beats the timeout.
        access(1, 0, 3'b010, 32'h140, 0, 3, 3, 32'hCAFE_F00D);

        // Timeout: request never accepted.
        @(negedge clk);
        mem_read_m = 1; funct3_m = 3'b010; addr_m = 32'h500;
        #1;
        chk("to_idle_stall", 32'(stall_m), 1);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("to_req_valid", 32'(bus.req_valid), 1);
            chk("to_no_error_yet", 32'(bus_error_m), 0);
            @(negedge clk);
        end
        #1;
        chk("to_bus_error", 32'(bus_error_m), 1);
        chk("to_done", 32'(done_m), 1);
        chk("to_read_data", read_data_m, 0);
        chk("to_req_dropped", 32'(bus.req_valid), 0);
        chk("to_stall", 32'(stall_m), 0);
        mem_read_m = 0;
        @(negedge clk);
        #1;
        chk("to_error_cleared", 32'(bus_error_m), 0);
        chk("to_idle_req", 32'(bus.req_valid), 0);

        // Reset while waiting for a response; late response must be ignored.
        access(1, 0, 3'b010, 32'h600, 0, 0, 0, 32'h1357_9BDF);
        @(negedge clk);
        mem_read_m = 1; funct3_m = 3'b010; addr_m = 32'h604;
        @(negedge clk);
        bus.req_ready = 1;
        @(negedge clk);
        bus.req_ready = 0;
        rst = 1; mem_read_m = 0;
        @(negedge clk);
        rst = 0;
        #1;
        chk("rst_mid_read_data", read_data_m, 0);
        chk("rst_mid_done", 32'(done_m), 0);
        chk("rst_mid_req_valid", 32'(bus.req_valid), 0);
        chk("rst_mid_req_addr", bus.req_addr, 0);
        chk("rst_mid_stall", 32'(stall_m), 0);
        @(negedge clk);
        bus.resp_valid = 1; bus.resp_rdata = 32'h1234_5678;
        @(negedge clk);
        bus.resp_valid = 0;
        #1;
        chk("late_resp_done", 32'(done_m), 0);
        chk("late_resp_data", read_data_m, 0);
        access(1, 0, 3'b010, 32'h700, 0, 0, 0, 32'h0BAD_F00D);

        // Randomized loads and stores against the lane model.
        for (int k = 0; k < 40; k++) begin
            bit ld;
            logic [2:0] f3;
            ld = $urandom_range(0, 1) == 1;
            f3 = ld ? ld_f3[$urandom_range(0, 6)] : st_f3[$urandom_range(0, 2)];
            access(ld, 0, f3, 32'h1000 + $urandom_range(0, 255), $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
